// File: rtl/uart_ext_of_verifla_pkg.sv
// Shared constants and FSM encodings for the logic-analyser host UART.
package uart_ext_of_verifla_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/baud_tick_of_verifla.sv
// Free-running divider producing a one-cycle pulse every CLK_DIV system clocks.
module baud_tick_of_verifla #(
    parameter int CLK_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = (r_cnt == LAST);

endmodule

// File: rtl/uart_ext_of_verifla.sv
// UART with 16x-oversampling receiver, configurable framing, held receive word
// and framing/parity/overrun flags.
module uart_ext_of_verifla
    import uart_ext_of_verifla_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 baud_tick_o,
    output logic                 txd_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_wen_i,
    output logic                 tx_ready_o,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_rdy_o,
    input  logic                 rx_ack_i,
    output logic                 rx_frame_err_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_overrun_o
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [3:0]    SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    SUB_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_EN    = (PARITY != PAR_NONE);
    localparam logic          PAR_INV   = (PARITY == PAR_ODD);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    logic w_tick;

    baud_tick_of_verifla #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (w_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state, w_tx_state;
    logic [3:0]           r_tx_sub, w_tx_sub;
    logic [BW-1:0]        r_tx_bit, w_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic                 r_tx_par, w_tx_par;
    logic                 r_tx_stop, w_tx_stop;
    logic                 r_txd, w_txd;
    logic                 r_tx_ready, w_tx_ready;
    logic                 w_tx_last;

    assign w_tx_last = w_tick && (r_tx_sub == SUB_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_sub   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_stop  <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_sub   <= w_tx_sub;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_par   <= w_tx_par;
            r_tx_stop  <= w_tx_stop;
            r_txd      <= w_txd;
            r_tx_ready <= w_tx_ready;
        end
    end

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_sub   = r_tx_sub;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_par   = r_tx_par;
        w_tx_stop  = r_tx_stop;
        w_txd      = r_txd;
        w_tx_ready = r_tx_ready;
        if (r_tx_state != TX_IDLE && w_tick) begin
            w_tx_sub = r_tx_sub + 1'b1;
        end
        case (r_tx_state)
            TX_IDLE: begin
                if (tx_wen_i) begin
                    w_tx_state = TX_START;
                    w_tx_shift = tx_data_i;
                    w_tx_par   = (^tx_data_i) ^ PAR_INV;
                    w_tx_sub   = '0;
                    w_tx_bit   = '0;
                    w_tx_stop  = 1'b0;
                    w_txd      = 1'b0;
                    w_tx_ready = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_last) begin
                    w_tx_state = TX_DATA;
                    w_txd      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_last) begin
                    if (r_tx_bit == BIT_LAST) begin
                        w_tx_state = PAR_EN ? TX_PARITY : TX_STOP;
                        w_txd      = PAR_EN ? r_tx_par : 1'b1;
                    end else begin
                        w_tx_bit   = r_tx_bit + 1'b1;
                        w_tx_shift = r_tx_shift >> 1;
                        w_txd      = r_tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_last) begin
                    w_tx_state = TX_STOP;
                    w_txd      = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_last) begin
                    if (r_tx_stop == STOP_LAST) begin
                        w_tx_state = TX_IDLE;
                        w_tx_ready = 1'b1;
                    end else begin
                        w_tx_stop = 1'b1;
                    end
                end
            end
            default: w_tx_state = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic                 r_rxd_meta, r_rxd_sync;
    rx_state_t            r_rx_state, w_rx_state;
    logic [3:0]           r_rx_sub, w_rx_sub;
    logic [BW-1:0]        r_rx_bit, w_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic                 r_rx_parbit, w_rx_parbit;
    logic                 r_rx_armed, w_rx_armed;
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data;
    logic                 r_rx_rdy, w_rx_rdy;
    logic                 r_rx_ferr, w_rx_ferr;
    logic                 r_rx_perr, w_rx_perr;
    logic                 r_rx_ovr, w_rx_ovr;
    logic                 w_rx_mid;

    assign w_rx_mid = w_tick && (r_rx_sub == SUB_MID);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rxd_meta  <= 1'b1;
            r_rxd_sync  <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_sub    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_parbit <= 1'b0;
            r_rx_armed  <= 1'b1;
            r_rx_data   <= '0;
            r_rx_rdy    <= 1'b0;
            r_rx_ferr   <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_rx_ovr    <= 1'b0;
        end else begin
            r_rxd_meta  <= rxd_i;
            r_rxd_sync  <= r_rxd_meta;
            r_rx_state  <= w_rx_state;
            r_rx_sub    <= w_rx_sub;
            r_rx_bit    <= w_rx_bit;
            r_rx_shift  <= w_rx_shift;
            r_rx_parbit <= w_rx_parbit;
            r_rx_armed  <= w_rx_armed;
            r_rx_data   <= w_rx_data;
            r_rx_rdy    <= w_rx_rdy;
            r_rx_ferr   <= w_rx_ferr;
            r_rx_perr   <= w_rx_perr;
            r_rx_ovr    <= w_rx_ovr;
        end
    end

    always_comb begin
        w_rx_state  = r_rx_state;
        w_rx_sub    = r_rx_sub;
        w_rx_bit    = r_rx_bit;
        w_rx_shift  = r_rx_shift;
        w_rx_parbit = r_rx_parbit;
        w_rx_armed  = r_rx_armed;
        w_rx_data   = r_rx_data;
        w_rx_rdy    = r_rx_rdy;
        w_rx_ferr   = r_rx_ferr;
        w_rx_perr   = r_rx_perr;
        w_rx_ovr    = r_rx_ovr;
        if (rx_ack_i) begin
            w_rx_rdy  = 1'b0;
            w_rx_ferr = 1'b0;
            w_rx_perr = 1'b0;
            w_rx_ovr  = 1'b0;
        end
        if (r_rx_state != RX_IDLE && w_tick) begin
            w_rx_sub = r_rx_sub + 1'b1;
        end
        case (r_rx_state)
            RX_IDLE: begin
                // After a bad stop bit the line must be seen high before re-arming.
                if (w_tick) begin
                    if (!r_rx_armed) begin
                        w_rx_armed = r_rxd_sync;
                    end else if (!r_rxd_sync) begin
                        w_rx_state = RX_START;
                        w_rx_sub   = '0;
                        w_rx_bit   = '0;
                    end
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    w_rx_state = r_rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_mid) begin
                    w_rx_shift = {r_rxd_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
                        w_rx_state = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_bit = r_rx_bit + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_rx_mid) begin
                    w_rx_parbit = r_rxd_sync;
                    w_rx_state  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_mid) begin
                    w_rx_state = RX_IDLE;
                    w_rx_armed = r_rxd_sync;
                    if (!r_rx_rdy || rx_ack_i) begin
                        w_rx_data = r_rx_shift;
                        w_rx_rdy  = 1'b1;
                        w_rx_ferr = !r_rxd_sync;
                        w_rx_perr = PAR_EN && ((^r_rx_shift) ^ r_rx_parbit ^ PAR_INV);
                    end else begin
                        w_rx_ovr = 1'b1;
                    end
                end
            end
            default: w_rx_state = RX_IDLE;
        endcase
    end

    assign baud_tick_o     = w_tick;
    assign txd_o           = r_txd;
    assign tx_ready_o      = r_tx_ready;
    assign rx_data_o       = r_rx_data;
    assign rx_rdy_o        = r_rx_rdy;
    assign rx_frame_err_o  = r_rx_ferr;
    assign rx_parity_err_o = r_rx_perr;
    assign rx_overrun_o    = r_rx_ovr;

endmodule

// File: tb/tb_uart_ext_of_verifla.sv
// Directed bench: 8N1 instance driven by hand, 8E1 and 7O2 instances in loopback.
module tb_uart_ext_of_verifla;

    localparam int CD   = 4;
    localparam int BITC = 16 * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1, receive line driven by the bench
    logic       a_tick, a_txd, a_ready, a_rdy, a_ferr, a_perr, a_ovr;
    logic       a_wen = 1'b0, a_rxd = 1'b1, a_ack = 1'b0;
    logic [7:0] a_tx_data = 8'h00, a_rx_data;
    // 8E1 loopback
    logic       b_tick, b_txd, b_ready, b_rdy, b_ferr, b_perr, b_ovr;
    logic       b_wen = 1'b0, b_ack = 1'b0;
    logic [7:0] b_tx_data = 8'h00, b_rx_data;
    // 7O2 loopback
    logic       c_tick, c_txd, c_ready, c_rdy, c_ferr, c_perr, c_ovr;
    logic       c_wen = 1'b0, c_ack = 1'b0;
    logic [6:0] c_tx_data = 7'h00, c_rx_data;

    uart_ext_of_verifla #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk_i(clk), .rst_i(rst), .baud_tick_o(a_tick), .txd_o(a_txd),
        .tx_data_i(a_tx_data), .tx_wen_i(a_wen), .tx_ready_o(a_ready),
        .rxd_i(a_rxd), .rx_data_o(a_rx_data), .rx_rdy_o(a_rdy), .rx_ack_i(a_ack),
        .rx_frame_err_o(a_ferr), .rx_parity_err_o(a_perr), .rx_overrun_o(a_ovr)
    );

    uart_ext_of_verifla #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk_i(clk), .rst_i(rst), .baud_tick_o(b_tick), .txd_o(b_txd),
        .tx_data_i(b_tx_data), .tx_wen_i(b_wen), .tx_ready_o(b_ready),
        .rxd_i(b_txd), .rx_data_o(b_rx_data), .rx_rdy_o(b_rdy), .rx_ack_i(b_ack),
        .rx_frame_err_o(b_ferr), .rx_parity_err_o(b_perr), .rx_overrun_o(b_ovr)
    );

    uart_ext_of_verifla #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk_i(clk), .rst_i(rst), .baud_tick_o(c_tick), .txd_o(c_txd),
        .tx_data_i(c_tx_data), .tx_wen_i(c_wen), .tx_ready_o(c_ready),
        .rxd_i(c_txd), .rx_data_o(c_rx_data), .rx_rdy_o(c_rdy), .rx_ack_i(c_ack),
        .rx_frame_err_o(c_ferr), .rx_parity_err_o(c_perr), .rx_overrun_o(c_ovr)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ferr;
    } rx_vec_t;

    typedef struct {
        logic       cfg;       // 0 = 8E1, 1 = 7O2
        logic [7:0] data;
        logic       exp_par;   // parity bit expected on the wire
    } lb_vec_t;

    rx_vec_t rx_tab[5];
    lb_vec_t lb_tab[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic a_bit(input logic v);
        a_rxd = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic a_frame(input logic [7:0] d, input logic stop);
        a_bit(1'b0);
        for (int i = 0; i < 8; i++) a_bit(d[i]);
        a_bit(stop);
    endtask

    task automatic pulse_ack(input int which);
        if (which == 0) a_ack = 1'b1;
        else if (which == 1) b_ack = 1'b1;
        else c_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        b_ack = 1'b0;
        c_ack = 1'b0;
    endtask

    // Send one word on a loopback instance and check what comes back.
    task automatic lb_send(input logic cfg, input logic [7:0] d, input logic exp_par, input int idx);
        int db;
        logic [7:0] exp_d;
        logic [7:0] got_d;
        db    = cfg ? 7 : 8;
        exp_d = cfg ? {1'b0, d[6:0]} : d;
        for (int k = 0; k < 8; k++) begin
            if (cfg ? c_tick : b_tick) break;
            @(negedge clk);
        end
        if (cfg) begin c_tx_data = d[6:0]; c_wen = 1'b1; end
        else begin b_tx_data = d; b_wen = 1'b1; end
        @(negedge clk);
        b_wen = 1'b0;
        c_wen = 1'b0;
        repeat ((1 + db) * BITC + BITC / 2) @(negedge clk);
        chk("lb_parity_bit", cfg ? c_txd : b_txd, exp_par);
        for (int k = 0; k < 2000; k++) begin
            if (cfg ? c_rdy : b_rdy) break;
            @(negedge clk);
        end
        got_d = cfg ? {1'b0, c_rx_data} : b_rx_data;
        chk("lb_rdy", cfg ? c_rdy : b_rdy, 1);
        chk("lb_data", got_d, exp_d);
        chk("lb_ferr", cfg ? c_ferr : b_ferr, 0);
        chk("lb_perr", cfg ? c_perr : b_perr, 0);
        chk("lb_ovr", cfg ? c_ovr : b_ovr, 0);
        $display("loopback %0d cfg=%0d sent=%h got=%h", idx, cfg, exp_d, got_d);
        pulse_ack(cfg ? 2 : 1);
        chk("lb_rdy_after_ack", cfg ? c_rdy : b_rdy, 0);
        for (int k = 0; k < 2000; k++) begin
            if (cfg ? c_ready : b_ready) break;
            @(negedge clk);
        end
        chk("lb_tx_ready", cfg ? c_ready : b_ready, 1);
    endtask

    initial begin
        int         match[10];
        int         low_cnt;
        int         tick_cnt;
        logic [9:0] exp_frame;

        rx_tab[0] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
        rx_tab[1] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b0};
        rx_tab[2] = '{data: 8'h81, stop: 1'b1, exp_ferr: 1'b0};
        rx_tab[3] = '{data: 8'h5A, stop: 1'b0, exp_ferr: 1'b1};
        rx_tab[4] = '{data: 8'hA5, stop: 1'b1, exp_ferr: 1'b0};

        lb_tab[0] = '{cfg: 1'b0, data: 8'hA3, exp_par: 1'b0};
        lb_tab[1] = '{cfg: 1'b0, data: 8'h00, exp_par: 1'b0};
        lb_tab[2] = '{cfg: 1'b0, data: 8'h01, exp_par: 1'b1};
        lb_tab[3] = '{cfg: 1'b0, data: 8'hFE, exp_par: 1'b1};
        lb_tab[4] = '{cfg: 1'b1, data: 8'h7F, exp_par: 1'b0};
        lb_tab[5] = '{cfg: 1'b1, data: 8'h2A, exp_par: 1'b0};
        lb_tab[6] = '{cfg: 1'b1, data: 8'h00, exp_par: 1'b1};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_a_txd", a_txd, 1);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_tick", a_tick, 0);
        chk("rst_a_rx_data", a_rx_data, 0);
        chk("rst_a_rdy", a_rdy, 0);
        chk("rst_a_errs", {a_ferr, a_perr, a_ovr}, 0);
        chk("rst_c_txd_ready", {c_txd, c_ready}, 2'b11);
        rst = 1'b0;

        tick_cnt = 0;
        for (int i = 0; i < 10 * CD; i++) begin
            @(negedge clk);
            if (a_tick) tick_cnt++;
        end
        chk("tick_rate", tick_cnt, 10);

        // 8N1 waveform for 0x55, with a request while busy that must be ignored
        for (int k = 0; k < 8; k++) begin
            if (a_tick) break;
            @(negedge clk);
        end
        a_tx_data = 8'h55;
        a_wen = 1'b1;
        @(negedge clk);
        a_wen = 1'b0;
        exp_frame = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) match[b] = 0;
        low_cnt = 0;
        for (int i = 0; i < 10 * BITC; i++) begin
            if (a_txd === exp_frame[i / BITC]) match[i / BITC]++;
            if (a_ready === 1'b0) low_cnt++;
            if (i == 100) begin a_tx_data = 8'h00; a_wen = 1'b1; end
            if (i == 101) a_wen = 1'b0;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) chk($sformatf("txd_bit%0d", b), match[b], BITC);
        chk("tx_ready_low_cycles", low_cnt, 10 * BITC);
        chk("tx_ready_back", a_ready, 1);
        chk("txd_idle", a_txd, 1);
        $display("tx 8N1 data=55 ready_low=%0d", low_cnt);

        // loopback table
        for (int v = 0; v < 7; v++) lb_send(lb_tab[v].cfg, lb_tab[v].data, lb_tab[v].exp_par, v);

        // hand-driven receive table
        for (int v = 0; v < 5; v++) begin
            a_frame(rx_tab[v].data, rx_tab[v].stop);
            a_bit(1'b1);
            a_bit(1'b1);
            chk("rx_rdy", a_rdy, 1);
            chk("rx_data", a_rx_data, rx_tab[v].data);
            chk("rx_ferr", a_ferr, rx_tab[v].exp_ferr);
            chk("rx_perr", a_perr, 0);
            chk("rx_ovr", a_ovr, 0);
            $display("rx %0d data=%h ferr=%0d", v, a_rx_data, a_ferr);
            pulse_ack(0);
            chk("rx_rdy_after_ack", a_rdy, 0);
            chk("rx_ferr_after_ack", a_ferr, 0);
        end

        // stop bit low, line held low: word kept, no re-arm until high
        a_frame(8'h3C, 1'b0);
        chk("ferr_hold_rdy", a_rdy, 1);
        chk("ferr_hold_flag", a_ferr, 1);
        chk("ferr_hold_data", a_rx_data, 8'h3C);
        pulse_ack(0);
        repeat (10 * BITC) @(negedge clk);
        chk("ferr_no_rearm_low", a_rdy, 0);
        a_bit(1'b1);
        a_bit(1'b1);
        a_frame(8'h96, 1'b1);
        a_bit(1'b1);
        chk("ferr_recover_rdy", a_rdy, 1);
        chk("ferr_recover_data", a_rx_data, 8'h96);
        chk("ferr_recover_flag", a_ferr, 0);
        $display("rx after frame error data=%h", a_rx_data);
        pulse_ack(0);

        // overrun
        a_frame(8'h11, 1'b1);
        a_bit(1'b1);
        a_frame(8'h22, 1'b1);
        a_bit(1'b1);
        chk("ovr_rdy", a_rdy, 1);
        chk("ovr_data_kept", a_rx_data, 8'h11);
        chk("ovr_flag", a_ovr, 1);
        $display("overrun held=%h ovr=%0d", a_rx_data, a_ovr);
        pulse_ack(0);
        chk("ovr_ack_flags", {a_rdy, a_ferr, a_perr, a_ovr}, 0);

        // false start: 5-tick glitch, then a real frame shortly after
        a_rxd = 1'b0;
        repeat (5 * CD) @(negedge clk);
        a_rxd = 1'b1;
        repeat (6 * CD) @(negedge clk);
        chk("glitch_no_rdy", a_rdy, 0);
        a_frame(8'h69, 1'b1);
        a_bit(1'b1);
        chk("glitch_then_rdy", a_rdy, 1);
        chk("glitch_then_data", a_rx_data, 8'h69);
        chk("glitch_then_ferr", a_ferr, 0);
        $display("rx after glitch data=%h", a_rx_data);
        pulse_ack(0);

        // reset mid-transmit / mid-receive on the 8E1 loopback
        for (int k = 0; k < 8; k++) begin
            if (b_tick) break;
            @(negedge clk);
        end
        b_tx_data = 8'h00;
        b_wen = 1'b1;
        @(negedge clk);
        b_wen = 1'b0;
        repeat (300) @(negedge clk);
        chk("pre_rst_txd", b_txd, 0);
        chk("pre_rst_ready", b_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_txd", b_txd, 1);
        chk("rst_mid_ready", b_ready, 1);
        chk("rst_mid_rdy", b_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset applied mid-frame");
        lb_send(1'b0, 8'hC6, 1'b0, 99);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
